// File: rtl/rv_isa_pkg.sv
// ---------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I encoding constants. The opcodes match the main decoder's case
// labels, so encoder and decoder cannot drift apart.
//   OP_*    : 7-bit major opcodes for the supported instruction classes
//   kind_e  : instruction class selector used on the loader's kind port
//   F3_*    : fixed funct3 values for lw/sw/beq
// ---------------------------------------------------------------------------
package rv_isa_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      KIND_LW  = 3'd0,
      KIND_SW  = 3'd1,
      KIND_R   = 3'd2,
      KIND_BEQ = 3'd3,
      KIND_I   = 3'd4,
      KIND_JAL = 3'd5
   } kind_e;

   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;

endpackage

// File: rtl/rv_word_pack.sv
// ---------------------------------------------------------------------------
// rv_word_pack
// Combinational RV32I word packer: maps an instruction class plus its fields
// onto a 32-bit machine word and flags whether the request is encodable.
//   i_kind     : instruction class (kind_e; 6 and 7 are illegal)
//   i_rd/i_rs1/i_rs2 : register numbers
//   i_funct3   : funct3 for R-type / I-type ALU
//   i_funct7b5 : bit 30 for R-type, and for I-type shifts (funct3=101)
//   i_imm      : 21-bit signed immediate (byte offset for beq/jal)
//   o_word     : encoded instruction (0 when illegal)
//   o_legal    : 1 when kind is known and the immediate fits
// ---------------------------------------------------------------------------
module rv_word_pack
   import rv_isa_pkg::*;
(
   input  logic [2:0]  i_kind,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7b5,
   input  logic [20:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);

   // Immediate fits a 12-bit (13-bit) signed field when every bit above the
   // field's sign bit is a copy of it.
   logic w_fit12;
   logic w_fit13;
   assign w_fit12 = (&i_imm[20:11]) | ~(|i_imm[20:11]);
   assign w_fit13 = (&i_imm[20:12]) | ~(|i_imm[20:12]);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b0;
      case (kind_e'(i_kind))
         KIND_LW: begin
            o_word  = {i_imm[11:0], i_rs1, F3_LW, i_rd, OP_LW};
            o_legal = w_fit12;
         end
         KIND_SW: begin
            o_word  = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OP_SW};
            o_legal = w_fit12;
         end
         KIND_R: begin
            o_word  = {1'b0, i_funct7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            o_legal = 1'b1;
         end
         KIND_BEQ: begin
            o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                       i_imm[4:1], i_imm[11], OP_BEQ};
            o_legal = w_fit13 & ~i_imm[0];
         end
         KIND_I: begin
            o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
            // srli/srai: bit 30 selects arithmetic shift, not an imm bit
            if (i_funct3 == 3'b101) o_word[30] = i_funct7b5;
            o_legal = w_fit12;
         end
         KIND_JAL: begin
            o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            o_legal = ~i_imm[0];
         end
         default: begin
            o_word  = '0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Accepts RV32I instruction fields over valid/ready, encodes them and writes
// the words sequentially into instruction memory starting at BASE_ADDR.
//   clk, reset        : clock, synchronous active-high reset
//   restart           : rewind to BASE_ADDR (only acted on in IDLE/FULL)
//   in_valid/in_ready : field handshake
//   kind..imm         : instruction fields
//   imem_we/waddr/wdata : one-cycle write port toward instruction memory
//   err               : one-cycle pulse on an unencodable request
//   full, word_count  : fill status since reset/restart
// Timing: accept edge -> ENC -> WR; write strobe visible after the WR edge,
// i.e. two cycles after the accept edge, one word every three cycles.
// ---------------------------------------------------------------------------
module instr_encoder_loader
   import rv_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64,
   localparam int         CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    kind,
   input  logic [4:0]    rd,
   input  logic [4:0]    rs1,
   input  logic [4:0]    rs2,
   input  logic [2:0]    funct3,
   input  logic          funct7b5,
   input  logic [20:0]   imm,
   output logic          imem_we,
   output logic [31:0]   imem_waddr,
   output logic [31:0]   imem_wdata,
   output logic          err,
   output logic          full,
   output logic [CW-1:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ENC  = 3'd1,
      S_WR   = 3'd2,
      S_ERR  = 3'd3,
      S_FULL = 3'd4
   } state_e;

   state_e        r_state;
   logic          r_in_ready;
   logic [2:0]    r_kind;
   logic [4:0]    r_rd, r_rs1, r_rs2;
   logic [2:0]    r_funct3;
   logic          r_funct7b5;
   logic [20:0]   r_imm;
   logic [31:0]   r_word;
   logic [31:0]   r_ptr;
   logic [CW-1:0] r_count;
   logic          r_we, r_err, r_full;
   logic [31:0]   r_waddr, r_wdata;

   logic [31:0]   w_word;
   logic          w_legal;

   rv_word_pack u_pack (
      .i_kind     (r_kind),
      .i_rd       (r_rd),
      .i_rs1      (r_rs1),
      .i_rs2      (r_rs2),
      .i_funct3   (r_funct3),
      .i_funct7b5 (r_funct7b5),
      .i_imm      (r_imm),
      .o_word     (w_word),
      .o_legal    (w_legal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_kind     <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_funct3   <= '0;
         r_funct7b5 <= 1'b0;
         r_imm      <= '0;
         r_word     <= '0;
         r_ptr      <= BASE_ADDR;
         r_count    <= '0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_full     <= 1'b0;
         r_waddr    <= BASE_ADDR;
         r_wdata    <= '0;
      end else begin
         r_we  <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE, S_FULL: begin
               if (restart) begin
                  // restart takes priority over a same-cycle in_valid
                  r_ptr      <= BASE_ADDR;
                  r_count    <= '0;
                  r_full     <= 1'b0;
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b1;
               end else if (r_state == S_IDLE) begin
                  r_in_ready <= 1'b1;
                  if (in_valid && r_in_ready) begin
                     r_kind     <= kind;
                     r_rd       <= rd;
                     r_rs1      <= rs1;
                     r_rs2      <= rs2;
                     r_funct3   <= funct3;
                     r_funct7b5 <= funct7b5;
                     r_imm      <= imm;
                     r_in_ready <= 1'b0;
                     r_state    <= S_ENC;
                  end
               end
            end
            S_ENC: begin
               r_word  <= w_word;
               r_state <= w_legal ? S_WR : S_ERR;
            end
            S_WR: begin
               r_we    <= 1'b1;
               r_waddr <= r_ptr;
               r_wdata <= r_word;
               r_ptr   <= r_ptr + 32'd4;
               r_count <= r_count + 1'b1;
               if (r_count == CW'(DEPTH - 1)) begin
                  r_full  <= 1'b1;
                  r_state <= S_FULL;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            S_ERR: begin
               r_err      <= 1'b1;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign imem_we    = r_we;
   assign imem_waddr = r_waddr;
   assign imem_wdata = r_wdata;
   assign err        = r_err;
   assign full       = r_full;
   assign word_count = r_count;

endmodule
